humidity_poll_ctrl: RTL and testbench

Scheduler and validator for the single-wire humidity/temperature sensor reader. It generates the read strobe that drives the reader's `flag_five_sec` input, and tracks the reader's state output to detect frame completion or a hung transaction. It checks each 40-bit frame's checksum, retries failed reads with a back-off, and publishes only validated humidity/temperature bytes to the rest of the smart-home design.

---
 rtl/humidity_poll_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_humidity_poll_ctrl.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/humidity_poll_ctrl.sv
// humidity_poll_ctrl: schedules reads of the single-wire humidity/temperature
// reader. It issues the read strobe, watches the reader state for completion
// or a hang, validates each 40-bit frame, retries with back-off and publishes
// only validated bytes.
module humidity_poll_ctrl #(
    parameter int PERIOD_US      = 5000000,
    parameter int RETRY_DELAY_US = 2000000,
    parameter int TIMEOUT_US     = 50000,
    parameter int MAX_RETRY      = 3,
    parameter int STROBE_LEN     = 4
) (
    input  logic        clk1M,
    input  logic        rst,
    input  logic        en,
    input  logic        force_req,
    input  logic [2:0]  rd_state,
    input  logic [39:0] hym_in,
    output logic        trig_out,
    output logic [7:0]  hum_int,
    output logic [7:0]  hum_dec,
    output logic [7:0]  temp_int,
    output logic [7:0]  temp_dec,
    output logic        data_valid,
    output logic        upd_pulse,
    output logic        err_cksum,
    output logic        err_timeout,
    output logic [7:0]  fail_cnt,
    output logic        busy
);

    typedef enum logic [2:0] {
        S_IDLE, S_TRIG, S_WAIT, S_CHECK, S_FAIL, S_BACKOFF
    } state_t;

    localparam logic [22:0] PER_LOAD  = 23'(PERIOD_US - 1);
    localparam logic [22:0] BO_LOAD   = 23'(RETRY_DELAY_US - 1);
    localparam logic [15:0] TO_LAST   = 16'(TIMEOUT_US - 1);
    localparam logic [15:0] STR_LAST  = 16'(STROBE_LEN - 1);
    localparam logic [7:0]  RETRY_MAX = 8'(MAX_RETRY);

    state_t      state_q, state_d;
    logic [22:0] per_q, per_d;        // period down-counter
    logic        poll_q, poll_d;      // pending scheduled poll
    logic [15:0] to_q, to_d;          // cycles since strobe start
    logic [22:0] bo_q, bo_d;          // back-off down-counter
    logic [7:0]  retry_q, retry_d;
    logic        seen_q, seen_d;      // reader reported "receiving"
    logic [31:0] data_q, data_d;      // {hum_int, hum_dec, temp_int, temp_dec}
    logic        dv_q, dv_d;
    logic        upd_q, upd_d;
    logic        eck_q, eck_d;
    logic        eto_q, eto_d;
    logic [7:0]  fail_q, fail_d;

    logic        per_hit;
    logic        rx_done;
    logic [9:0]  sum10;
    logic        frame_ok;

    // Period hit is used in the same cycle so the first strobe lands exactly
    // PERIOD_US cycles after reset release.
    assign per_hit  = en && (per_q == '0);
    assign rx_done  = seen_q && (rd_state == 3'd3);
    assign sum10    = {2'b00, hym_in[39:32]} + {2'b00, hym_in[31:24]}
                    + {2'b00, hym_in[23:16]} + {2'b00, hym_in[15:8]};
    // An all-zero payload sums correctly but means the sensor never answered.
    assign frame_ok = ((sum10 & 10'h0FF) == {2'b00, hym_in[7:0]})
                   && (hym_in[39:8] != '0);

    // Next-state and datapath updates for the poll/validate sequence.
    always_comb begin
        state_d = state_q;
        per_d   = per_q;
        poll_d  = poll_q;
        to_d    = to_q;
        bo_d    = bo_q;
        retry_d = retry_q;
        seen_d  = seen_q;
        data_d  = data_q;
        dv_d    = dv_q;
        upd_d   = 1'b0;
        eck_d   = eck_q;
        eto_d   = eto_q;
        fail_d  = fail_q;

        if (en) per_d = per_hit ? PER_LOAD : per_q - 23'd1;

        // Polls that fall due during a transaction are dropped, not queued.
        if (state_q != S_IDLE) poll_d = 1'b0;
        else if (per_hit)      poll_d = 1'b1;

        case (state_q)
            S_IDLE: begin
                if (en && (poll_q || per_hit || force_req)) begin
                    state_d = S_TRIG;
                    poll_d  = 1'b0;
                    retry_d = '0;
                end
            end
            S_TRIG: begin
                to_d = to_q + 16'd1;
                if (to_q == STR_LAST) state_d = S_WAIT;
            end
            S_WAIT: begin
                to_d = to_q + 16'd1;
                if (rd_state == 3'd2) seen_d = 1'b1;
                if (rx_done) begin
                    state_d = S_CHECK;
                end else if (to_q == TO_LAST) begin
                    eto_d   = 1'b1;
                    state_d = S_FAIL;
                end
            end
            S_CHECK: begin
                if (frame_ok) begin
                    data_d  = hym_in[39:8];
                    upd_d   = 1'b1;
                    dv_d    = 1'b1;
                    eck_d   = 1'b0;
                    eto_d   = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    eck_d   = 1'b1;
                    state_d = S_FAIL;
                end
            end
            S_FAIL: begin
                if (fail_q != 8'hFF) fail_d = fail_q + 8'd1;
                if (retry_q < RETRY_MAX) begin
                    retry_d = retry_q + 8'd1;
                    bo_d    = BO_LOAD;
                    state_d = S_BACKOFF;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_BACKOFF: begin
                if (!en)              state_d = S_IDLE;
                else if (bo_q == '0)  state_d = S_TRIG;
                else                  bo_d    = bo_q - 23'd1;
            end
            default: state_d = S_IDLE;
        endcase

        // Every strobe starts with a fresh timeout window and receive flag.
        if (state_d == S_TRIG && state_q != S_TRIG) begin
            to_d   = '0;
            seen_d = 1'b0;
        end
    end

    // State and datapath registers; reset aborts any transaction at once.
    always_ff @(posedge clk1M or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            per_q   <= PER_LOAD;
            poll_q  <= 1'b0;
            to_q    <= '0;
            bo_q    <= '0;
            retry_q <= '0;
            seen_q  <= 1'b0;
            data_q  <= '0;
            dv_q    <= 1'b0;
            upd_q   <= 1'b0;
            eck_q   <= 1'b0;
            eto_q   <= 1'b0;
            fail_q  <= '0;
        end else begin
            state_q <= state_d;
            per_q   <= per_d;
            poll_q  <= poll_d;
            to_q    <= to_d;
            bo_q    <= bo_d;
            retry_q <= retry_d;
            seen_q  <= seen_d;
            data_q  <= data_d;
            dv_q    <= dv_d;
            upd_q   <= upd_d;
            eck_q   <= eck_d;
            eto_q   <= eto_d;
            fail_q  <= fail_d;
        end
    end

    assign trig_out    = (state_q == S_TRIG);
    assign busy        = (state_q != S_IDLE);
    assign hum_int     = data_q[31:24];
    assign hum_dec     = data_q[23:16];
    assign temp_int    = data_q[15:8];
    assign temp_dec    = data_q[7:0];
    assign data_valid  = dv_q;
    assign upd_pulse   = upd_q;
    assign err_cksum   = eck_q;
    assign err_timeout = eto_q;
    assign fail_cnt    = fail_q;

endmodule

// File: tb/tb_humidity_poll_ctrl.sv
// Directed bench for humidity_poll_ctrl with reduced timing parameters.
// Published frames are checked through a scoreboard queue.
module tb_humidity_poll_ctrl;

    logic        clk1M = 1'b0;
    logic        rst, en, force_req;
    logic [2:0]  rd_state;
    logic [39:0] hym_in;
    logic        trig_out, data_valid, upd_pulse, err_cksum, err_timeout, busy;
    logic [7:0]  hum_int, hum_dec, temp_int, temp_dec, fail_cnt;

    int          n_pass  = 0;
    int          n_total = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    logic [31:0] exp_q[$];

    humidity_poll_ctrl #(
        .PERIOD_US(1000), .RETRY_DELAY_US(200), .TIMEOUT_US(100),
        .MAX_RETRY(2), .STROBE_LEN(4)
    ) dut (
        .clk1M(clk1M), .rst(rst), .en(en), .force_req(force_req),
        .rd_state(rd_state), .hym_in(hym_in), .trig_out(trig_out),
        .hum_int(hum_int), .hum_dec(hum_dec), .temp_int(temp_int),
        .temp_dec(temp_dec), .data_valid(data_valid), .upd_pulse(upd_pulse),
        .err_cksum(err_cksum), .err_timeout(err_timeout),
        .fail_cnt(fail_cnt), .busy(busy)
    );

    always #500 clk1M = ~clk1M;

    // cycles since reset release: at the negedge after edge k, cyc == k
    always @(posedge clk1M or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk1M);
    endtask

    task automatic wait_trig(input int limit);
        int w = 0;
        while (!trig_out && w < limit) begin tick(1); w++; end
        chk("strobe_seen", 64'(trig_out), 64'd1);
    endtask

    task automatic wait_fall(output int w);
        w = 0;
        while (trig_out && w < 20) begin tick(1); w++; end
    endtask

    task automatic count_hi(input int n, output int hi);
        hi = 0;
        repeat (n) begin tick(1); if (trig_out) hi++; end
    endtask

    // reader model: start pulse, receiving, then done with the frame
    task automatic reader_frame(input logic [39:0] d);
        rd_state = 3'd1; tick(3);
        rd_state = 3'd2; tick(5);
        hym_in = d; rd_state = 3'd3;
    endtask

    // scoreboard: every update must match the oldest expected frame
    always @(negedge clk1M) begin
        if (!rst && upd_pulse) begin
            if (exp_q.size() == 0) chk("upd_spurious", 64'd1, 64'd0);
            else chk("upd_bytes", 64'({hum_int, hum_dec, temp_int, temp_dec}),
                     64'(exp_q.pop_front()));
        end
    end

    initial begin
        int w, n, hi, off_cyc, exp_hit;
        logic prev;
        rst = 1'b1; en = 1'b1; force_req = 1'b0; rd_state = 3'd3; hym_in = '0;
        tick(3);
        chk("rst_trig",  64'(trig_out), 64'd0);
        chk("rst_busy",  64'(busy), 64'd0);
        chk("rst_valid", 64'(data_valid), 64'd0);
        chk("rst_bytes", 64'({hum_int, hum_dec, temp_int, temp_dec, fail_cnt}), 64'd0);
        chk("rst_flags", 64'({upd_pulse, err_cksum, err_timeout}), 64'd0);
        rst = 1'b0;

        // scheduled read: bad checksum, then good frame on the retry
        wait_trig(1100);
        chk("first_strobe_cyc", 64'(cyc), 64'd1000);
        wait_fall(w);
        chk("strobe_width", 64'(w), 64'd4);
        reader_frame(40'h3500170064);
        tick(2);
        chk("bad_cksum_flag", 64'(err_cksum), 64'd1);
        chk("bad_no_valid", 64'(data_valid), 64'd0);
        w = 0;
        while (!trig_out && w < 400) begin tick(1); w++; end
        chk("retry_gap", 64'(w), 64'd201);
        wait_fall(w);
        exp_q.push_back(32'h35001700);
        reader_frame(40'h350017004C);
        tick(2);
        chk("good_upd", 64'(upd_pulse), 64'd1);
        chk("good_valid", 64'(data_valid), 64'd1);
        chk("good_clr_cksum", 64'(err_cksum), 64'd0);
        chk("good_idle", 64'(busy), 64'd0);
        chk("good_failcnt", 64'(fail_cnt), 64'd1);
        tick(1);
        chk("upd_one_cycle", 64'(upd_pulse), 64'd0);

        // timeout: reader stuck at done, never receiving
        wait_trig(1000);
        chk("period2_cyc", 64'(cyc), 64'd2000);
        w = 0;
        while (!err_timeout && w < 200) begin tick(1); w++; end
        chk("timeout_latency", 64'(w), 64'd100);
        n = 1; prev = 1'b0;
        while (cyc < 2990) begin
            tick(1);
            if (trig_out && !prev) n++;
            prev = trig_out;
        end
        chk("timeout_strobes", 64'(n), 64'd3);
        chk("timeout_failcnt", 64'(fail_cnt), 64'd4);  // includes the earlier bad checksum
        chk("timeout_idle", 64'(busy), 64'd0);
        chk("timeout_flag", 64'(err_timeout), 64'd1);

        // all-zero frame rejected; then enable dropped during back-off
        wait_trig(100);
        chk("period3_cyc", 64'(cyc), 64'd3000);
        wait_fall(w);
        reader_frame(40'h0);
        tick(2);
        chk("zero_cksum_flag", 64'(err_cksum), 64'd1);
        chk("zero_keep_bytes", 64'({hum_int, hum_dec, temp_int, temp_dec}), 64'h35001700);
        chk("zero_keep_valid", 64'(data_valid), 64'd1);
        tick(1);
        chk("backoff_busy", 64'(busy), 64'd1);
        chk("zero_failcnt", 64'(fail_cnt), 64'd5);
        off_cyc = cyc; en = 1'b0;
        tick(1);
        chk("en_low_to_idle", 64'(busy), 64'd0);
        force_req = 1'b1; tick(1); force_req = 1'b0;
        count_hi(300, hi);
        chk("en_low_no_strobe", 64'(hi), 64'd0);
        // counter was frozen while en was low, so the hit moves out by that much
        exp_hit = 4000 + (cyc - off_cyc);
        en = 1'b1;

        // force in IDLE, then force + period expiry ignored while busy
        tick(exp_hit - 50 - cyc);
        chk("pre_force_idle", 64'(trig_out), 64'd0);
        force_req = 1'b1; tick(1); force_req = 1'b0;
        chk("force_next_cycle", 64'(trig_out), 64'd1);
        wait_fall(w);
        rd_state = 3'd1; tick(3);
        rd_state = 3'd2; tick(10);
        force_req = 1'b1; tick(1); force_req = 1'b0;
        tick(exp_hit + 5 - cyc);
        chk("busy_past_period", 64'(busy), 64'd1);
        exp_q.push_back(32'h40051903);
        hym_in = 40'h4005190361; rd_state = 3'd3;
        tick(2);
        chk("force_upd", 64'(upd_pulse), 64'd1);
        chk("force_clr_timeout", 64'(err_timeout), 64'd0);
        chk("force_clr_cksum", 64'(err_cksum), 64'd0);
        count_hi(300, hi);
        chk("no_extra_strobe", 64'(hi), 64'd0);

        // reset in WAIT clears everything asynchronously
        wait_trig(1000);
        chk("period_after_force", 64'(cyc), 64'(exp_hit + 1000));
        wait_fall(w);
        rd_state = 3'd1; tick(3);
        rd_state = 3'd2; tick(2);
        chk("wait_busy", 64'(busy), 64'd1);
        #100 rst = 1'b1;
        #1;
        chk("arst_busy", 64'(busy), 64'd0);
        chk("arst_trig", 64'(trig_out), 64'd0);
        chk("arst_valid", 64'(data_valid), 64'd0);
        chk("arst_bytes", 64'({hum_int, hum_dec, temp_int, temp_dec, fail_cnt}), 64'd0);
        chk("arst_flags", 64'({upd_pulse, err_cksum, err_timeout}), 64'd0);
        @(negedge clk1M);
        tick(2);
        rst = 1'b0;
        wait_trig(1100);
        chk("strobe_after_reset", 64'(cyc), 64'd1000);

        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
